// File: rtl/multi_mode_ff_bank.sv
`default_nettype none
// ============================================================================
// Module      : multi_mode_ff_bank
// Description : Bank of WIDTH independent flip-flops sharing one run-time
//               selectable personality (SR, JK, D or T). Illegal SR input
//               combinations are flagged per bit in a sticky vector and
//               counted in a saturating event counter.
// Ports       : clk      - rising-edge clock
//               rst      - asynchronous active-high reset
//               en       - update enable for q / error state
//               mode_in  - next mode (00 SR, 01 JK, 10 D, 11 T)
//               mode_ld  - load strobe for mode_in (acts even when en=0)
//               a, b     - per-bit S/J/D/T and R/K inputs
//               clr_err  - clears err_vec / err_cnt (acts even when en=0)
//               q, qbar  - registered state and its registered complement
//               cur_mode - mode currently applied
//               err_vec  - sticky per-bit illegal-SR flags
//               err_cnt  - saturating count of illegal-SR cycles
// Revision    : 1.0 - initial release
// ============================================================================
module multi_mode_ff_bank #(
    parameter int WIDTH = 8,
    parameter int ECW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode_in,
    input  logic             mode_ld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [1:0]       cur_mode,
    output logic [WIDTH-1:0] err_vec,
    output logic [ECW-1:0]   err_cnt
);

    localparam logic [1:0]     c_MODE_SR = 2'b00;
    localparam logic [1:0]     c_MODE_JK = 2'b01;
    localparam logic [1:0]     c_MODE_D  = 2'b10;
    localparam logic [1:0]     c_MODE_T  = 2'b11;
    localparam logic [ECW-1:0] c_CNT_MAX = {ECW{1'b1}};
    localparam logic [ECW-1:0] c_CNT_ONE = {{(ECW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qbar;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_err_vec;
    logic [ECW-1:0]   r_err_cnt;

    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_illegal;
    logic             w_any_illegal;
    logic [WIDTH-1:0] w_err_vec_next;
    logic [ECW-1:0]   w_err_cnt_next;

    // Per-bit next-state under the currently applied mode. The edge that
    // loads a new mode still evaluates with r_mode, i.e. the old mode.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic w_nxt;
            always_comb begin
                w_nxt = r_q[gi];
                case (r_mode)
                    c_MODE_SR: begin
                        // 11 is illegal and holds, so q/qbar stay complementary
                        if (a[gi] && !b[gi])      w_nxt = 1'b1;
                        else if (!a[gi] && b[gi]) w_nxt = 1'b0;
                    end
                    c_MODE_JK: begin
                        case ({a[gi], b[gi]})
                            2'b10:   w_nxt = 1'b1;
                            2'b01:   w_nxt = 1'b0;
                            2'b11:   w_nxt = ~r_q[gi];
                            default: w_nxt = r_q[gi];
                        endcase
                    end
                    c_MODE_D: w_nxt = a[gi];
                    c_MODE_T: w_nxt = a[gi] ? ~r_q[gi] : r_q[gi];
                    default:  w_nxt = r_q[gi];
                endcase
            end
            assign w_q_next[gi] = w_nxt;
        end
    endgenerate

    // Illegal events only count when the bank actually updates in SR mode.
    assign w_illegal     = (en && (r_mode == c_MODE_SR)) ? (a & b) : '0;
    assign w_any_illegal = |w_illegal;

    // A clear on the same edge as an illegal cycle restarts the error state
    // from that cycle's offenders rather than dropping them.
    always_comb begin
        w_err_vec_next = r_err_vec | w_illegal;
        w_err_cnt_next = r_err_cnt;
        if (clr_err) begin
            w_err_vec_next = w_illegal;
            w_err_cnt_next = w_any_illegal ? c_CNT_ONE : '0;
        end else if (w_any_illegal && (r_err_cnt != c_CNT_MAX)) begin
            w_err_cnt_next = r_err_cnt + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            r_qbar    <= '1;
            r_mode    <= c_MODE_SR;
            r_err_vec <= '0;
            r_err_cnt <= '0;
        end else begin
            if (mode_ld) begin
                r_mode <= mode_in;
            end
            if (en) begin
                r_q    <= w_q_next;
                r_qbar <= ~w_q_next;
            end
            r_err_vec <= w_err_vec_next;
            r_err_cnt <= w_err_cnt_next;
        end
    end

    assign q        = r_q;
    assign qbar     = r_qbar;
    assign cur_mode = r_mode;
    assign err_vec  = r_err_vec;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multi_mode_ff_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_mode_ff_bank
// Description : Directed self-checking bench for multi_mode_ff_bank
//               (WIDTH=8, ECW=8). Inputs change and outputs are sampled
//               1 time unit after the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_mode_ff_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode_in;
    logic       mode_ld;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr_err;
    logic [7:0] q;
    logic [7:0] qbar;
    logic [1:0] cur_mode;
    logic [7:0] err_vec;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    multi_mode_ff_bank #(.WIDTH(8), .ECW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode_in  (mode_in),
        .mode_ld  (mode_ld),
        .a        (a),
        .b        (b),
        .clr_err  (clr_err),
        .q        (q),
        .qbar     (qbar),
        .cur_mode (cur_mode),
        .err_vec  (err_vec),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (q !== 8'h00)      begin errors++; $display("FAIL reset_q got=%h exp=%h", q, 8'h00); end
        checks++; if (qbar !== 8'hFF)   begin errors++; $display("FAIL reset_qbar got=%h exp=%h", qbar, 8'hFF); end
        checks++; if (cur_mode !== 2'b00) begin errors++; $display("FAIL reset_mode got=%b exp=%b", cur_mode, 2'b00); end
        checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL reset_errvec got=%h exp=%h", err_vec, 8'h00); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_errcnt got=%h exp=%h", err_cnt, 8'h00); end
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_sr();
        en = 1'b1; a = 8'h0F; b = 8'hF0;
        tick();
        checks++; if (q !== 8'h0F)    begin errors++; $display("FAIL sr_set q got=%h exp=%h", q, 8'h0F); end
        checks++; if (qbar !== 8'hF0) begin errors++; $display("FAIL sr_set qbar got=%h exp=%h", qbar, 8'hF0); end
        a = 8'h00; b = 8'h00;
        tick();
        checks++; if (q !== 8'h0F)    begin errors++; $display("FAIL sr_hold q got=%h exp=%h", q, 8'h0F); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL sr_hold errcnt got=%h exp=%h", err_cnt, 8'h00); end
    endtask

    task automatic test_sr_illegal_sat();
        a = 8'h81; b = 8'h81;
        tick();
        checks++; if (q !== 8'h0F)       begin errors++; $display("FAIL ill_q got=%h exp=%h", q, 8'h0F); end
        checks++; if (qbar !== 8'hF0)    begin errors++; $display("FAIL ill_qbar got=%h exp=%h", qbar, 8'hF0); end
        checks++; if (err_vec !== 8'h81) begin errors++; $display("FAIL ill_errvec got=%h exp=%h", err_vec, 8'h81); end
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL ill_errcnt got=%h exp=%h", err_cnt, 8'h01); end
        repeat (253) tick();
        checks++; if (err_cnt !== 8'hFE) begin errors++; $display("FAIL ill_cnt254 got=%h exp=%h", err_cnt, 8'hFE); end
        tick();
        checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL ill_cnt255 got=%h exp=%h", err_cnt, 8'hFF); end
        repeat (45) tick();
        checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL ill_sat got=%h exp=%h", err_cnt, 8'hFF); end
        a = 8'h00; b = 8'h00; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (err_vec !== 8'h00) begin errors++; $display("FAIL clr_errvec got=%h exp=%h", err_vec, 8'h00); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL clr_errcnt got=%h exp=%h", err_cnt, 8'h00); end
    endtask

    task automatic test_mode_ld();
        a = 8'hFF; b = 8'hFF; mode_in = 2'b01; mode_ld = 1'b1;
        tick();
        mode_ld = 1'b0;
        checks++; if (q !== 8'h0F)        begin errors++; $display("FAIL ld_q got=%h exp=%h", q, 8'h0F); end
        checks++; if (err_vec !== 8'hFF)  begin errors++; $display("FAIL ld_errvec got=%h exp=%h", err_vec, 8'hFF); end
        checks++; if (err_cnt !== 8'h01)  begin errors++; $display("FAIL ld_errcnt got=%h exp=%h", err_cnt, 8'h01); end
        checks++; if (cur_mode !== 2'b01) begin errors++; $display("FAIL ld_mode got=%b exp=%b", cur_mode, 2'b01); end
        tick();
        checks++; if (q !== 8'hF0)       begin errors++; $display("FAIL jk_tog q got=%h exp=%h", q, 8'hF0); end
        checks++; if (qbar !== 8'h0F)    begin errors++; $display("FAIL jk_tog qbar got=%h exp=%h", qbar, 8'h0F); end
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL jk_errcnt got=%h exp=%h", err_cnt, 8'h01); end
        a = 8'h03; b = 8'h30;
        tick();
        checks++; if (q !== 8'hC3)       begin errors++; $display("FAIL jk_setclr q got=%h exp=%h", q, 8'hC3); end
    endtask

    task automatic test_t_mode();
        en = 1'b0; mode_in = 2'b10; mode_ld = 1'b1;
        tick();
        mode_ld = 1'b0;
        checks++; if (cur_mode !== 2'b10) begin errors++; $display("FAIL en0_mode got=%b exp=%b", cur_mode, 2'b10); end
        checks++; if (q !== 8'hC3)        begin errors++; $display("FAIL en0_hold q got=%h exp=%h", q, 8'hC3); end
        en = 1'b1; a = 8'h00; b = 8'hFF;
        tick();
        checks++; if (q !== 8'h00)        begin errors++; $display("FAIL d_q got=%h exp=%h", q, 8'h00); end
        en = 1'b0; mode_in = 2'b11; mode_ld = 1'b1;
        tick();
        mode_ld = 1'b0;
        en = 1'b1; a = 8'h01;
        tick();
        checks++; if (q !== 8'h01) begin errors++; $display("FAIL t1 q got=%h exp=%h", q, 8'h01); end
        tick();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL t2 q got=%h exp=%h", q, 8'h00); end
        en = 1'b0;
        tick();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL t3 q got=%h exp=%h", q, 8'h00); end
        en = 1'b1;
        tick();
        checks++; if (q !== 8'h01)    begin errors++; $display("FAIL t4 q got=%h exp=%h", q, 8'h01); end
        checks++; if (qbar !== 8'hFE) begin errors++; $display("FAIL t4 qbar got=%h exp=%h", qbar, 8'hFE); end
    endtask

    task automatic test_clr_err();
        en = 1'b0; mode_in = 2'b00; mode_ld = 1'b1; a = 8'h00; b = 8'h00;
        tick();
        mode_ld = 1'b0;
        en = 1'b1; a = 8'h04; b = 8'h04; clr_err = 1'b1;
        tick();
        clr_err = 1'b0; a = 8'h00; b = 8'h00;
        checks++; if (err_vec !== 8'h04) begin errors++; $display("FAIL clrill_errvec got=%h exp=%h", err_vec, 8'h04); end
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL clrill_errcnt got=%h exp=%h", err_cnt, 8'h01); end
        checks++; if (q !== 8'h01)       begin errors++; $display("FAIL clrill_q got=%h exp=%h", q, 8'h01); end
    endtask

    task automatic test_async_reset();
        en = 1'b0; mode_in = 2'b10; mode_ld = 1'b1;
        tick();
        mode_ld = 1'b0;
        en = 1'b1; a = 8'hA5;
        tick();
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL dmode_q got=%h exp=%h", q, 8'hA5); end
        mode_in = 2'b11; mode_ld = 1'b1; clr_err = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (q !== 8'h00)        begin errors++; $display("FAIL arst_q got=%h exp=%h", q, 8'h00); end
        checks++; if (qbar !== 8'hFF)     begin errors++; $display("FAIL arst_qbar got=%h exp=%h", qbar, 8'hFF); end
        checks++; if (cur_mode !== 2'b00) begin errors++; $display("FAIL arst_mode got=%b exp=%b", cur_mode, 2'b00); end
        checks++; if (err_vec !== 8'h00)  begin errors++; $display("FAIL arst_errvec got=%h exp=%h", err_vec, 8'h00); end
        checks++; if (err_cnt !== 8'h00)  begin errors++; $display("FAIL arst_errcnt got=%h exp=%h", err_cnt, 8'h00); end
        tick();
        checks++; if (cur_mode !== 2'b00) begin errors++; $display("FAIL arst_hold_mode got=%b exp=%b", cur_mode, 2'b00); end
        #2 rst = 1'b0; mode_ld = 1'b0; clr_err = 1'b0; en = 1'b0; a = 8'h3C; b = 8'h00;
        tick();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL post_rst_en0 q got=%h exp=%h", q, 8'h00); end
        en = 1'b1;
        tick();
        checks++; if (q !== 8'h3C)    begin errors++; $display("FAIL post_rst_sr q got=%h exp=%h", q, 8'h3C); end
        checks++; if (qbar !== 8'hC3) begin errors++; $display("FAIL post_rst_sr qbar got=%h exp=%h", qbar, 8'hC3); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode_in = 2'b00; mode_ld = 1'b0;
        a = 8'h00; b = 8'h00; clr_err = 1'b0;
        test_reset();
        test_sr();
        test_sr_illegal_sat();
        test_mode_ld();
        test_t_mode();
        test_clr_err();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_mode_ff_bank.md
MULTI_MODE_FF_BANK -- requirements
Module: multi_mode_ff_bank

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WIDTH  8  number of independent flip-flop bits.
  ECW  8  width of the illegal-event counter.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge active.
  rst  in  1  asynchronous, active-high reset.
  en  in  1  update enable; 0 freezes all state except clear and mode load.
  mode_in  in  2  next mode: 00 SR, 01 JK, 10 D, 11 T.
  mode_ld  in  1  load strobe for mode_in.
  a  in  WIDTH  per-bit S / J / D / T input.
  b  in  WIDTH  per-bit R / K input; ignored in D and T modes.
  clr_err  in  1  clears error status.
  q  out  WIDTH  registered state.
  qbar  out  WIDTH  registered complement of q.
  cur_mode  out  2  currently applied mode.
  err_vec  out  WIDTH  sticky per-bit illegal-SR flags.
  err_cnt  out  ECW  saturating count of illegal-SR cycles.

Function
REQ-003 All state SHALL update only on the rising edge of clk, except the reset defined in REQ-014.
REQ-004 When mode_ld=1, cur_mode SHALL take mode_in at the edge; the edge that loads the mode SHALL still use the old cur_mode.
REQ-005 When en=1 and cur_mode=SR, each bit i SHALL behave as follows:
  a=0, b=0: hold.
  a=1, b=0: q=1.
  a=0, b=1: q=0.
  a=1, b=1: illegal; hold q.
REQ-006 When en=1 and cur_mode=JK, each bit SHALL behave as follows:
  00: hold.
  10: set.
  01: clear.
  11: toggle.
REQ-007 When en=1 and cur_mode=D, q[i] SHALL take a[i]; b SHALL be ignored.
REQ-008 When en=1 and cur_mode=T, q[i] SHALL toggle when a[i]=1 and hold otherwise; b SHALL be ignored.
REQ-009 When en=0, q, err_vec and err_cnt SHALL hold; mode_ld and clr_err SHALL still act.
REQ-010 qbar SHALL equal ~q at every edge and after reset; q and qbar SHALL never be X or equal, including for illegal SR inputs.
REQ-011 An illegal SR cycle (en=1, cur_mode=SR, a[i]&b[i]=1 for any i) SHALL set err_vec[i] for each offending bit.
  - err_vec bits SHALL be sticky.
  - err_cnt SHALL increment by 1 per illegal cycle, regardless of how many bits offend.
  - err_cnt SHALL saturate at all-ones.
REQ-012 clr_err=1 SHALL clear err_vec and err_cnt at the edge; if an illegal cycle occurs on the same edge, err_vec SHALL equal the new offending bits and err_cnt SHALL equal 1.
REQ-013 Update latency SHALL be one cycle: the input at edge n SHALL be visible on q after edge n.

Reset
REQ-014 While rst=1, independent of clk, the outputs SHALL be:
  q = 0.
  qbar = all ones.
  cur_mode = 00.
  err_vec = 0.
  err_cnt = 0.
REQ-015 When rst deasserts, the first update SHALL occur at the next rising edge of clk with en=1.
REQ-016 Reset asserted mid-operation SHALL discard any pending mode load or clear.

Verification
REQ-017 The bench SHALL cover these scenarios (WIDTH=8, ECW=8):
  - SR mode, a=0x0F, b=0xF0 -> q=0x0F, qbar=0xF0; then a=b=0x00 -> q holds 0x0F.
  - SR mode, q=0x0F, a=0x81, b=0x81 -> q=0x0F, err_vec=0x81, err_cnt=1; repeat 300 cycles -> err_cnt=0xFF (saturated).
  - mode_in=01 with mode_ld=1 and a=b=0xFF on the same edge -> SR illegal handling applies, cur_mode=01 afterwards; next edge with a=b=0xFF -> q toggles.
  - T mode, a=0x01, 4 cycles, en=0 on the 3rd -> q[0] sequence 1, 0, 0, 1.
  - clr_err on the same edge as an illegal SR cycle on bit 2 -> err_vec=0x04, err_cnt=1.
  - rst pulsed between clock edges mid-run in D mode -> q=0x00, qbar=0xFF, cur_mode=00 immediately, without waiting for a clk edge.
